// File: rtl/redmule_pkg.sv
// rtl/redmule_pkg.sv - shared RedMulE constants and X load controller state type
package redmule_pkg;

   localparam int unsigned ARRAY_WIDTH = 12;
   localparam int unsigned DW          = 288;

   typedef enum logic [2:0] {
      X_LOAD_IDLE       = 3'd0,
      X_LOAD_LOAD       = 3'd1,
      X_LOAD_PAD        = 3'd2,
      X_LOAD_WAIT_FULL  = 3'd3,
      X_LOAD_WAIT_EMPTY = 3'd4
   } x_load_state_e;

endpackage

// File: rtl/redmule_x_load_reg.sv
// rtl/redmule_x_load_reg.sv - registered X buffer write stage with zero-force for padding rows
module redmule_x_load_reg
   import redmule_pkg::*;
#(
   parameter int unsigned DW = redmule_pkg::DW
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clear_i,
   input  logic          load_i,
   input  logic          zero_i,
   input  logic [DW-1:0] data_i,
   output logic          load_o,
   output logic [DW-1:0] data_o
);

   // Strobe follows the request by one cycle; data only moves on a load so it stays quiet otherwise.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         load_o <= 1'b0;
         data_o <= '0;
      end else if (clear_i) begin
         load_o <= 1'b0;
         data_o <= '0;
      end else begin
         load_o <= load_i;
         if (load_i) begin
            data_o <= zero_i ? '0 : data_i;
         end
      end
   end

endmodule

// File: rtl/redmule_x_load_ctrl.sv
// rtl/redmule_x_load_ctrl.sv - X streamer to X buffer write controller with tile sequencing and padding
module redmule_x_load_ctrl
   import redmule_pkg::*;
#(
   parameter int unsigned DW = redmule_pkg::DW,
   parameter int unsigned W  = ARRAY_WIDTH,
   localparam int unsigned CW = $clog2(W) + 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clear_i,
   input  logic          start_i,
   input  logic [15:0]   tiles_i,
   input  logic [CW-1:0] width_i,
   input  logic [CW-1:0] last_rows_i,
   input  logic [DW-1:0] x_stream_data_i,
   input  logic          x_stream_valid_i,
   output logic          x_stream_ready_o,
   output logic          x_load_o,
   output logic [DW-1:0] x_data_o,
   input  logic          x_full_i,
   input  logic          x_empty_i,
   output logic          x_rst_w_index_o,
   output logic          busy_o,
   output logic          done_o
);

   x_load_state_e state_q, state_d;

   logic [CW-1:0] row_cnt_q;
   logic [15:0]   tile_cnt_q;
   logic [15:0]   tiles_q;
   logic [CW-1:0] width_q;
   logic [CW-1:0] last_rows_q;

   logic [CW-1:0] lim;
   logic [CW-1:0] row_inc;
   logic [15:0]   tile_inc;
   logic          last_tile;
   logic          stream_open;
   logic          accept;
   logic          load_req;
   logic          pad_zero;

   assign row_inc     = row_cnt_q + CW'(1);
   assign tile_inc    = tile_cnt_q + 16'd1;
   assign last_tile   = (tile_inc == tiles_q);
   assign lim         = last_tile ? last_rows_q : width_q;
   assign stream_open = (state_q == X_LOAD_LOAD) && (row_cnt_q < lim);
   assign accept      = x_stream_valid_i && stream_open;

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= X_LOAD_IDLE;
      end else if (clear_i) begin
         state_q <= X_LOAD_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: stream rows, pad a short last tile, then wait out the buffer's full/empty cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         X_LOAD_IDLE:       if (start_i) state_d = X_LOAD_LOAD;
         X_LOAD_LOAD:       if (accept && (row_inc == lim))
                               state_d = (lim < width_q) ? X_LOAD_PAD : X_LOAD_WAIT_FULL;
         X_LOAD_PAD:        if (row_inc == width_q) state_d = X_LOAD_WAIT_FULL;
         X_LOAD_WAIT_FULL:  if (x_full_i) state_d = X_LOAD_WAIT_EMPTY;
         X_LOAD_WAIT_EMPTY: if (x_empty_i) state_d = last_tile ? X_LOAD_IDLE : X_LOAD_LOAD;
         default:           state_d = X_LOAD_IDLE;
      endcase
   end

   // Outputs and load requests decoded from the current state.
   always_comb begin
      x_stream_ready_o = 1'b0;
      load_req         = 1'b0;
      pad_zero         = 1'b0;
      x_rst_w_index_o  = 1'b0;
      done_o           = 1'b0;
      busy_o           = (state_q != X_LOAD_IDLE);
      unique case (state_q)
         X_LOAD_LOAD: begin
            x_stream_ready_o = stream_open;
            load_req         = accept;
         end
         X_LOAD_PAD: begin
            load_req = 1'b1;
            pad_zero = 1'b1;
         end
         X_LOAD_WAIT_EMPTY: begin
            x_rst_w_index_o = x_empty_i;
            done_o          = x_empty_i && last_tile;
         end
         default: ;
      endcase
   end

   // Job configuration and row/tile counters.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         row_cnt_q   <= '0;
         tile_cnt_q  <= '0;
         tiles_q     <= '0;
         width_q     <= '0;
         last_rows_q <= '0;
      end else if (clear_i) begin
         row_cnt_q   <= '0;
         tile_cnt_q  <= '0;
         tiles_q     <= '0;
         width_q     <= '0;
         last_rows_q <= '0;
      end else begin
         if ((state_q == X_LOAD_IDLE) && start_i) begin
            tiles_q     <= tiles_i;
            width_q     <= width_i;
            last_rows_q <= last_rows_i;
            row_cnt_q   <= '0;
            tile_cnt_q  <= '0;
         end
         if (accept || (state_q == X_LOAD_PAD)) begin
            row_cnt_q <= row_inc;
         end
         if (x_rst_w_index_o) begin
            row_cnt_q  <= '0;
            tile_cnt_q <= tile_inc;
         end
      end
   end

   redmule_x_load_reg #(
      .DW (DW)
   ) i_x_load_reg (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .load_i  (load_req),
      .zero_i  (pad_zero),
      .data_i  (x_stream_data_i),
      .load_o  (x_load_o),
      .data_o  (x_data_o)
   );

endmodule

// File: tb/tb_redmule_x_load_ctrl.sv
// tb/tb_redmule_x_load_ctrl.sv - self-checking bench for redmule_x_load_ctrl
`timescale 1ns/1ps
module tb_redmule_x_load_ctrl;
   import redmule_pkg::*;

   localparam int unsigned TDW = DW;
   localparam int unsigned TW  = 12;
   localparam int unsigned TCW = $clog2(TW) + 1;

   logic           clk_i = 1'b0;
   logic           rst_ni = 1'b0;
   logic           clear_i = 1'b0;
   logic           start_i = 1'b0;
   logic [15:0]    tiles_i = '0;
   logic [TCW-1:0] width_i = '0;
   logic [TCW-1:0] last_rows_i = '0;
   logic [TDW-1:0] x_stream_data_i = '0;
   logic           x_stream_valid_i = 1'b0;
   logic           x_stream_ready_o;
   logic           x_load_o;
   logic [TDW-1:0] x_data_o;
   logic           x_full_i;
   logic           x_empty_i = 1'b0;
   logic           x_rst_w_index_o;
   logic           busy_o;
   logic           done_o;

   always #5 clk_i = ~clk_i;

   redmule_x_load_ctrl #(
      .DW (TDW),
      .W  (TW)
   ) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .clear_i          (clear_i),
      .start_i          (start_i),
      .tiles_i          (tiles_i),
      .width_i          (width_i),
      .last_rows_i      (last_rows_i),
      .x_stream_data_i  (x_stream_data_i),
      .x_stream_valid_i (x_stream_valid_i),
      .x_stream_ready_o (x_stream_ready_o),
      .x_load_o         (x_load_o),
      .x_data_o         (x_data_o),
      .x_full_i         (x_full_i),
      .x_empty_i        (x_empty_i),
      .x_rst_w_index_o  (x_rst_w_index_o),
      .busy_o           (busy_o),
      .done_o           (done_o)
   );

   // X buffer stand-in: counts loads, reports full once a tile's rows are all written.
   int buf_cnt;
   int buf_width = 0;
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) buf_cnt <= 0;
      else if (clear_i || x_rst_w_index_o) buf_cnt <= 0;
      else if (x_load_o) buf_cnt <= buf_cnt + 1;
   end
   assign x_full_i = (buf_width > 0) && (buf_cnt >= buf_width);

   int n_checks = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [TDW-1:0] act, input logic [TDW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [TDW-1:0] pat(input int job, input int beat);
      logic [31:0] w;
      w = {8'hA5, job[7:0], beat[15:0]};
      return {(TDW/32){w}};
   endfunction

   // Behavioural model: a stream window per tile, owed pad rows, and a tile retired on empty after full.
   int cyc = 0;
   bit m_busy, m_open, m_load_next, full_prev;
   logic [TDW-1:0] m_data_next;
   int m_tiles, m_width, m_last, m_tile, m_acc, m_pad_owed;
   int n_load = 0, n_pad = 0, n_rst = 0, n_done = 0, n_accept = 0;
   int start_cyc, lat_last = -1, rst_cyc, gap_last = -1;
   bit want_lat, want_gap;

   always @(negedge clk_i) begin : monitor
      bit exp_rst, exp_done, acc, nxt_load, was_busy;
      logic [TDW-1:0] nxt_data;
      int lim;
      cyc++;
      if (!rst_ni) begin
         m_busy = 0; m_open = 0; m_load_next = 0; full_prev = 0;
         m_data_next = '0; m_tile = 0; m_acc = 0; m_pad_owed = 0;
         m_tiles = 1; m_width = 1; m_last = 1;
      end
      lim      = (m_tile == m_tiles - 1) ? m_last : m_width;
      exp_rst  = m_busy && !m_open && (m_pad_owed == 0) && !m_load_next && full_prev && x_empty_i;
      exp_done = exp_rst && (m_tile + 1 == m_tiles);

      chk("busy", busy_o, m_busy);
      chk("ready", x_stream_ready_o, m_open);
      chk("load", x_load_o, m_load_next);
      if (m_load_next) chk("data", x_data_o, m_data_next);
      chk("rst_w_index", x_rst_w_index_o, exp_rst);
      chk("done", done_o, exp_done);

      if (x_load_o) n_load++;
      if (x_load_o && (x_data_o == '0)) n_pad++;
      if (x_rst_w_index_o) n_rst++;
      if (done_o) n_done++;
      if (x_stream_valid_i && x_stream_ready_o) n_accept++;
      if (x_load_o && want_lat) begin lat_last = cyc - start_cyc; want_lat = 0; end
      if (x_load_o && want_gap) begin gap_last = cyc - rst_cyc; want_gap = 0; end
      if (x_rst_w_index_o && !done_o) begin rst_cyc = cyc; want_gap = 1; end

      if (rst_ni) begin
         was_busy = m_busy;
         acc      = x_stream_valid_i && m_open;
         nxt_load = 0;
         nxt_data = '0;
         if (acc) begin
            nxt_load = 1;
            nxt_data = x_stream_data_i;
         end else if (m_pad_owed > 0) begin
            nxt_load = 1;
            m_pad_owed--;
         end
         if (acc) begin
            m_acc++;
            if (m_acc == lim) begin
               m_open = 0;
               if (lim < m_width) m_pad_owed = m_width - lim;
            end
         end
         if (exp_rst) begin
            m_tile++;
            m_acc = 0;
            if (m_tile == m_tiles) m_busy = 0;
            else m_open = 1;
         end
         if (start_i && !was_busy) begin
            m_busy = 1; m_open = 1; m_tile = 0; m_acc = 0; m_pad_owed = 0;
            m_tiles = int'(tiles_i); m_width = int'(width_i); m_last = int'(last_rows_i);
            start_cyc = cyc; want_lat = 1;
         end
         if (clear_i) begin
            m_busy = 0; m_open = 0; m_pad_owed = 0; m_acc = 0; m_tile = 0;
            nxt_load = 0; nxt_data = '0;
         end
         m_load_next = nxt_load;
         m_data_next = nxt_data;
         full_prev   = x_full_i;
      end
   end

   // One job: start pulse, streamed rows, buffer empty pulse after full, optional mid-job clear.
   task automatic run_job(input int job, input int tiles, input int width, input int last,
                          input bit bubble, input int empty_delay, input int clear_after,
                          output int beats);
      int  full_cycles;
      bit  took, fullseen, doneseen, finished;
      beats       = 0;
      full_cycles = 0;
      finished    = 0;
      @(posedge clk_i); #1;
      tiles_i          = 16'(tiles);
      width_i          = TCW'(width);
      last_rows_i      = TCW'(last);
      buf_width        = width;
      start_i          = 1'b1;
      x_stream_valid_i = 1'b1;
      x_stream_data_i  = pat(job, 0);
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk_i);
         took     = x_stream_valid_i && x_stream_ready_o;
         fullseen = x_full_i;
         doneseen = done_o;
         @(posedge clk_i); #1;
         if (took) beats++;
         if (fullseen) full_cycles++;
         else full_cycles = 0;
         start_i   = (c == 3);
         tiles_i   = (c == 3) ? 16'd7 : 16'(tiles);
         x_empty_i = (c == 2) || (full_cycles == empty_delay);
         if (doneseen) begin
            finished = 1;
            break;
         end
         if ((clear_after > 0) && (beats == clear_after)) begin
            clear_i          = 1'b1;
            x_stream_valid_i = 1'b0;
            x_empty_i        = 1'b0;
            @(posedge clk_i); #1;
            clear_i = 1'b0;
            @(negedge clk_i);
            chk("clear_data_zero", x_data_o, '0);
            chk("clear_busy_low", busy_o, 1'b0);
            chk("clear_load_low", x_load_o, 1'b0);
            finished = 1;
            break;
         end
         x_stream_valid_i = bubble ? c[0] : 1'b1;
         x_stream_data_i  = pat(job, beats);
      end
      chk("job_finished", finished, 1'b1);
      start_i          = 1'b0;
      x_empty_i        = 1'b0;
      x_stream_valid_i = 1'b0;
   endtask

   initial begin
      int beats, b_load, b_pad, b_rst, b_done, b_acc;
      repeat (3) @(negedge clk_i);
      chk("reset_ready", x_stream_ready_o, 1'b0);
      chk("reset_load", x_load_o, 1'b0);
      chk("reset_data", x_data_o, '0);
      chk("reset_busy", busy_o, 1'b0);
      chk("reset_done", done_o, 1'b0);
      chk("reset_rst_w_index", x_rst_w_index_o, 1'b0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      repeat (2) @(posedge clk_i);

      // Single full tile
      b_load = n_load; b_pad = n_pad; b_rst = n_rst; b_done = n_done;
      run_job(1, 1, 12, 12, 0, 3, 0, beats);
      chk("t1_loads", n_load - b_load, 12);
      chk("t1_pads", n_pad - b_pad, 0);
      chk("t1_rst", n_rst - b_rst, 1);
      chk("t1_done", n_done - b_done, 1);
      chk("t1_first_load_latency", lat_last, 2);

      // Padded last tile
      b_load = n_load; b_pad = n_pad; b_done = n_done;
      run_job(2, 2, 8, 3, 0, 3, 0, beats);
      chk("t2_loads", n_load - b_load, 16);
      chk("t2_pads", n_pad - b_pad, 5);
      chk("t2_beats", beats, 11);
      chk("t2_done", n_done - b_done, 1);

      // Bubbles and backpressure
      b_load = n_load; b_acc = n_accept;
      run_job(3, 1, 4, 4, 1, 2, 0, beats);
      chk("t3_beats", beats, 4);
      chk("t3_accepts", n_accept - b_acc, 4);
      chk("t3_loads", n_load - b_load, 4);

      // Empty gating
      b_load = n_load; b_rst = n_rst;
      run_job(4, 2, 4, 4, 0, 20, 0, beats);
      chk("t4_loads", n_load - b_load, 8);
      chk("t4_rst", n_rst - b_rst, 2);
      chk("t4_empty_to_load", gap_last, 2);

      // Mid-tile clear, then restart
      b_load = n_load;
      run_job(5, 1, 8, 8, 0, 2, 4, beats);
      chk("t5_clear_beats", beats, 4);
      chk("t5_clear_loads", n_load - b_load, 4);
      b_load = n_load;
      run_job(6, 1, 8, 8, 0, 2, 0, beats);
      chk("t5_restart_loads", n_load - b_load, 8);
      chk("t5_restart_latency", lat_last, 2);

      // Width 1
      b_load = n_load; b_rst = n_rst; b_done = n_done;
      run_job(7, 3, 1, 1, 0, 1, 0, beats);
      chk("t6_loads", n_load - b_load, 3);
      chk("t6_rst", n_rst - b_rst, 3);
      chk("t6_done", n_done - b_done, 1);

      repeat (3) @(posedge clk_i);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
